// File: rtl/servo_pos_ramp_pkg.sv
// Shared servo command definitions: FSM state encodings and the board-level defaults
// (25 MHz clock, 20 ms frame, 1.0/2.0 ms pulse widths) used by the ramp and the PWM generator.
package servo_pos_ramp_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_UP   = 2'd1,
    S_DOWN = 2'd2
  } ramp_state_t;

  localparam int CLK_HZ          = 25_000_000;
  localparam int FRAME_CYCLES    = CLK_HZ / 50;
  localparam int DEBOUNCE_DFLT   = CLK_HZ / 100;
  localparam int PW_MIN_DFLT     = 25_000;
  localparam int PW_MAX_DFLT     = 50_000;
  localparam int PW_W_DFLT       = 17;
  localparam int STEP_DFLT       = 1_250;

  // Counter width able to hold 0..n (never below one bit).
  function automatic int cnt_width(input int n);
    return ($clog2(n + 1) < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/servo_pos_ramp_sw_debounce.sv
// Two-flop synchroniser plus stability counter for the raw position switch; sw_db follows
// the synchronised input only after it has differed for DEBOUNCE_CYCLES consecutive cycles.
module sw_debounce
  import servo_pos_ramp_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DFLT
) (
  input  logic clk,
  input  logic rst,
  input  logic sw,
  output logic sw_db
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      sw_db <= 1'b0;
    end else begin
      sync1 <= sw;
      sync2 <= sync1;
      // Any return to the accepted level restarts the qualification window.
      if (sync2 != sw_db) begin
        if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          sw_db <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/servo_pos_ramp.sv
// Servo command stage: debounced switch -> target width -> frame-aligned width updates.
// SERVO_RAMP_EN defined: slew-limited ramp of STEP per frame; undefined: jump straight to target.
//
// state  | meaning
// S_IDLE | pulse_width == target (or last tick left nothing to do)
// S_UP   | ramping toward a higher target, not reached yet
// S_DOWN | ramping toward a lower target, not reached yet
module servo_pos_ramp
  import servo_pos_ramp_pkg::*;
#(
  parameter int PW_W            = PW_W_DFLT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DFLT,
  parameter int PW_MIN          = PW_MIN_DFLT,
  parameter int PW_MAX          = PW_MAX_DFLT,
  parameter int STEP            = STEP_DFLT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sw,
  input  logic            frame_tick,
  output logic [PW_W-1:0] pulse_width,
  output logic            pw_valid,
  output logic            busy,
  output logic            at_target
);

  localparam logic [PW_W-1:0] PW_MIN_V = PW_W'(PW_MIN);
  localparam logic [PW_W-1:0] PW_MAX_V = PW_W'(PW_MAX);

  if (STEP < 1 || STEP >= PW_MAX - PW_MIN) begin : g_bad_step
    $error("servo_pos_ramp: STEP must be > 0 and < PW_MAX-PW_MIN");
  end

  logic            sw_db;
  logic [PW_W-1:0] target;
  logic [PW_W-1:0] pw_d;
  ramp_state_t     state_q;
  ramp_state_t     state_d;

  sw_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_sw_debounce (
    .clk  (clk),
    .rst  (rst),
    .sw   (sw),
    .sw_db(sw_db)
  );

`ifdef SERVO_RAMP_EN
  localparam logic [PW_W:0] STEP_X = (PW_W + 1)'(STEP);

  logic [PW_W:0] pw_x;
  logic [PW_W:0] tgt_x;
  logic [PW_W:0] up_x;

  assign pw_x  = {1'b0, pulse_width};
  assign tgt_x = {1'b0, target};
  assign up_x  = pw_x + STEP_X;
`endif

  // Direction is re-evaluated from target at every tick, so a reversal never costs a frame.
  always_comb begin
    state_d = state_q;
    pw_d    = pulse_width;
    if (frame_tick) begin
`ifdef SERVO_RAMP_EN
      if (tgt_x > pw_x) begin
        if (up_x >= tgt_x) begin
          pw_d    = target;
          state_d = S_IDLE;
        end else begin
          pw_d    = up_x[PW_W-1:0];
          state_d = S_UP;
        end
      end else if (tgt_x < pw_x) begin
        if (pw_x <= tgt_x + STEP_X) begin
          pw_d    = target;
          state_d = S_IDLE;
        end else begin
          pw_d    = pulse_width - STEP_X[PW_W-1:0];
          state_d = S_DOWN;
        end
      end else begin
        state_d = S_IDLE;
      end
`else
      pw_d    = target;
      state_d = S_IDLE;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pulse_width <= PW_MIN_V;
      target      <= PW_MIN_V;
      pw_valid    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pulse_width <= pw_d;
      target      <= sw_db ? PW_MAX_V : PW_MIN_V;
      pw_valid    <= (pw_d != pulse_width);
    end
  end

  assign busy      = (pulse_width != target);
  assign at_target = (pulse_width == target);

endmodule

// File: tb/tb_servo_pos_ramp.sv
// Self-checking bench for servo_pos_ramp: directed scenarios plus randomized traffic, all
// compared against a frame-level behavioural model of debounce, target and width updates.
module tb_servo_pos_ramp;

  localparam int D    = 4;
  localparam int PMIN = 100;
  localparam int PMAX = 200;
  localparam int STP  = 30;
`ifdef SERVO_RAMP_EN
  localparam bit RAMP = 1'b1;
`else
  localparam bit RAMP = 1'b0;
`endif
  localparam int HI_MARK = RAMP ? 160 : 200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sw = 1'b0;
  logic        frame_tick = 1'b0;
  logic [16:0] pulse_width;
  logic        pw_valid;
  logic        busy;
  logic        at_target;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  bit tick_en = 1'b0;
  bit rand_tick = 1'b0;

  int m_pw = PMIN;
  int m_tgt = PMIN;
  bit m_db = 1'b0;
  bit m_valid = 1'b0;
  bit hist[$];
  int seen[$];

  servo_pos_ramp #(
    .PW_W(17), .DEBOUNCE_CYCLES(D), .PW_MIN(PMIN), .PW_MAX(PMAX), .STEP(STP)
  ) dut (
    .clk(clk), .rst(rst), .sw(sw), .frame_tick(frame_tick),
    .pulse_width(pulse_width), .pw_valid(pw_valid), .busy(busy), .at_target(at_target)
  );

  always #20 clk = ~clk;

  // Apply one cycle of inputs, advance one rising edge, update the model, then step 1 time unit past the edge.
  task automatic drive_cycle(input bit sw_v, input bit rst_v);
    bit t, toggle;
    int npw;
    t = rand_tick ? ($urandom_range(0, 9) == 0) : (tick_en && (cyc % 50 == 49));
    sw = sw_v;
    rst = rst_v;
    frame_tick = t;
    @(posedge clk);
    if (rst_v) begin
      m_pw = PMIN; m_tgt = PMIN; m_db = 1'b0; m_valid = 1'b0;
      hist.delete();
      for (int i = 0; i < D + 2; i++) hist.push_back(1'b0);
    end else begin
      // Accept a new level once the switch, seen two samples late, has differed for D edges running.
      toggle = 1'b1;
      for (int i = 0; i < D; i++)
        if (hist[hist.size() - 2 - i] == m_db) toggle = 1'b0;
      npw = m_pw;
      if (t && m_tgt != m_pw) begin
        if (!RAMP) npw = m_tgt;
        else if (m_tgt > m_pw) npw = (m_pw + STP > m_tgt) ? m_tgt : m_pw + STP;
        else npw = (m_pw - STP < m_tgt) ? m_tgt : m_pw - STP;
      end
      m_valid = (npw != m_pw);
      m_pw = npw;
      m_tgt = m_db ? PMAX : PMIN;
      if (toggle) m_db = !m_db;
      hist.push_back(sw_v);
      void'(hist.pop_front());
    end
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    tick_en = 1'b0;
    drive_cycle(1'b0, 1'b1);
    drive_cycle(1'b0, 1'b1);
    n_cmp++;
    if ({pulse_width, pw_valid, busy, at_target} !== {17'd100, 1'b0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL reset_state got pw=%0d v=%b busy=%b at=%b want pw=100 v=0 busy=0 at=1",
               pulse_width, pw_valid, busy, at_target);
    end
    for (int i = 0; i < 60; i++) begin
      drive_cycle(1'b0, 1'b0);
      n_cmp++;
      if ({pulse_width, pw_valid, busy, at_target} !== {17'(m_pw), m_valid, m_pw != m_tgt, m_pw == m_tgt}) begin
        n_err++;
        $display("FAIL reset_hold cyc=%0d got pw=%0d v=%b busy=%b want pw=%0d v=%b busy=%b",
                 cyc, pulse_width, pw_valid, busy, m_pw, m_valid, m_pw != m_tgt);
      end
    end
  endtask

  task automatic test_ramp_up();
    int lat = 0;
    int exp_q[$];
    tick_en = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      drive_cycle(1'b1, 1'b0);
      if (busy === 1'b1 && lat == 0) lat = i;
    end
    n_cmp++;
    if (lat != D + 3) begin
      n_err++;
      $display("FAIL debounce_latency got %0d edges want %0d", lat, D + 3);
    end
    tick_en = 1'b1;
    seen.delete();
    for (int i = 0; i < 260; i++) begin
      drive_cycle(1'b1, 1'b0);
      if (pw_valid === 1'b1) seen.push_back(int'(pulse_width));
      n_cmp++;
      if ({pulse_width, pw_valid, busy, at_target} !== {17'(m_pw), m_valid, m_pw != m_tgt, m_pw == m_tgt}) begin
        n_err++;
        $display("FAIL ramp_up cyc=%0d got pw=%0d v=%b busy=%b want pw=%0d v=%b busy=%b",
                 cyc, pulse_width, pw_valid, busy, m_pw, m_valid, m_pw != m_tgt);
      end
    end
    if (RAMP) exp_q = '{130, 160, 190, 200};
    else exp_q = '{200};
    n_cmp++;
    if (seen != exp_q) begin
      n_err++;
      $display("FAIL ramp_up_seq got %0d updates (last %0d) want %0d updates (last %0d)",
               seen.size(), (seen.size() > 0) ? seen[$] : -1, exp_q.size(), exp_q[$]);
    end
  endtask

  task automatic test_glitch();
    int nvalid = 0;
    tick_en = 1'b1;
    for (int i = 0; i < 300; i++) drive_cycle(1'b0, 1'b0);
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < 6; i++) begin
        drive_cycle(i < 3, 1'b0);
        if (pw_valid === 1'b1) nvalid++;
        n_cmp++;
        if ({pulse_width, pw_valid, busy, at_target} !== {17'(m_pw), m_valid, m_pw != m_tgt, m_pw == m_tgt}) begin
          n_err++;
          $display("FAIL glitch cyc=%0d got pw=%0d v=%b busy=%b want pw=%0d v=%b busy=%b",
                   cyc, pulse_width, pw_valid, busy, m_pw, m_valid, m_pw != m_tgt);
        end
      end
    end
    n_cmp++;
    if (nvalid != 0 || pulse_width !== 17'd100) begin
      n_err++;
      $display("FAIL glitch_reject got pw=%0d valids=%0d want pw=100 valids=0", pulse_width, nvalid);
    end
  endtask

  task automatic test_reverse();
    bit hit = 1'b0;
    int exp_q[$];
    tick_en = 1'b1;
    for (int i = 0; i < 400 && !hit; i++) begin
      drive_cycle(1'b1, 1'b0);
      if (pulse_width === 17'(HI_MARK)) hit = 1'b1;
    end
    n_cmp++;
    if (!hit) begin
      n_err++;
      $display("FAIL reverse_reach got pw=%0d want %0d within 400 cycles", pulse_width, HI_MARK);
    end
    seen.delete();
    for (int i = 0; i < 200; i++) begin
      drive_cycle(1'b0, 1'b0);
      if (pw_valid === 1'b1) seen.push_back(int'(pulse_width));
      n_cmp++;
      if ({pulse_width, pw_valid, busy, at_target} !== {17'(m_pw), m_valid, m_pw != m_tgt, m_pw == m_tgt}) begin
        n_err++;
        $display("FAIL reverse cyc=%0d got pw=%0d v=%b busy=%b want pw=%0d v=%b busy=%b",
                 cyc, pulse_width, pw_valid, busy, m_pw, m_valid, m_pw != m_tgt);
      end
    end
    if (RAMP) exp_q = '{130, 100};
    else exp_q = '{100};
    n_cmp++;
    if (seen != exp_q) begin
      n_err++;
      $display("FAIL reverse_seq got %0d updates (first %0d) want %0d updates (first %0d)",
               seen.size(), (seen.size() > 0) ? seen[0] : -1, exp_q.size(), exp_q[0]);
    end
  endtask

  task automatic test_reset_mid();
    bit hit = 1'b0;
    int lat = 0;
    tick_en = 1'b1;
    for (int i = 0; i < 400 && !hit; i++) begin
      drive_cycle(1'b1, 1'b0);
      if (pulse_width === 17'(HI_MARK)) hit = 1'b1;
    end
    n_cmp++;
    if (!hit) begin
      n_err++;
      $display("FAIL midrst_reach got pw=%0d want %0d within 400 cycles", pulse_width, HI_MARK);
    end
    drive_cycle(1'b1, 1'b1);
    n_cmp++;
    if ({pulse_width, pw_valid, busy, at_target} !== {17'd100, 1'b0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL midrst_state got pw=%0d v=%b busy=%b at=%b want pw=100 v=0 busy=0 at=1",
               pulse_width, pw_valid, busy, at_target);
    end
    for (int i = 1; i <= 300; i++) begin
      drive_cycle(1'b1, 1'b0);
      if (busy === 1'b1 && lat == 0) lat = i;
      n_cmp++;
      if ({pulse_width, pw_valid, busy, at_target} !== {17'(m_pw), m_valid, m_pw != m_tgt, m_pw == m_tgt}) begin
        n_err++;
        $display("FAIL midrst_run cyc=%0d got pw=%0d v=%b busy=%b want pw=%0d v=%b busy=%b",
                 cyc, pulse_width, pw_valid, busy, m_pw, m_valid, m_pw != m_tgt);
      end
    end
    n_cmp++;
    if (lat != D + 3 || pulse_width !== 17'd200) begin
      n_err++;
      $display("FAIL midrst_redebounce got busy after %0d edges pw=%0d want %0d edges pw=200",
               lat, pulse_width, D + 3);
    end
  endtask

  task automatic test_random();
    bit sv = 1'b0;
    int hold = 0;
    tick_en = 1'b1;
    rand_tick = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        sv = 1'($urandom_range(0, 1));
        hold = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 120) : $urandom_range(1, 8);
      end
      hold--;
      drive_cycle(sv, $urandom_range(0, 499) == 0);
      n_cmp++;
      if ({pulse_width, pw_valid, busy, at_target} !== {17'(m_pw), m_valid, m_pw != m_tgt, m_pw == m_tgt}) begin
        n_err++;
        $display("FAIL random cyc=%0d got pw=%0d v=%b busy=%b at=%b want pw=%0d v=%b busy=%b",
                 cyc, pulse_width, pw_valid, busy, at_target, m_pw, m_valid, m_pw != m_tgt);
      end
    end
    rand_tick = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_glitch();
    test_reverse();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
